// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 16-bit CPU control path.
//   state_e    - stage_ctrl FSM states (binary encoded)
//   CLS_*      - opcode class values taken from opcode[4:3]
//   OP_HLT     - halt opcode
//   STORE_BIT  - opcode bit that marks a memory op as a store
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MUX    = 4'd3,
    S_ALU    = 4'd4,
    S_MEM    = 4'd5,
    S_WB     = 4'd6,
    S_PAUSE  = 4'd7,
    S_HALT   = 4'd8,
    S_ERR    = 4'd9
  } state_e;

  localparam logic [1:0] CLS_REG = 2'b00;
  localparam logic [1:0] CLS_IMM = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_CTL = 2'b11;

  localparam logic [4:0] OP_HLT    = 5'b11111;
  localparam int         STORE_BIT = 0;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles for stage_ctrl.
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - clear the count (held while the FSM is outside MEM)
//   en        - count one wait cycle (MEM with mem_ready low)
//   timeout   - count has reached MEM_TIMEOUT
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == W'(MEM_TIMEOUT));

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so all flops
  // see the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stage_ctrl.sv
// stage_ctrl: multi-cycle sequencer for the 16-bit CPU datapath.
// Walks each instruction through FETCH, DECODE, MUX, ALU, [MEM], WB raising
// one stage enable at a time.
//   clk, rst        - clock, asynchronous active-low reset
//   start           - leave IDLE/HALT; ignored while busy
//   halt_req        - stop after the current WB (sampled in WB only)
//   opcode          - instruction opcode, valid from DECODE onward
//   mem_ready       - memory access complete
//   step            - single-step advance (only with STAGE_CTRL_STEP_EN)
//   en_*            - one-hot stage enables
//   alu_in_sel      - 1: rs_q, 0: offset (latched in DECODE)
//   mem_we          - store qualifier during MEM
//   pc_inc          - PC advance pulse (WB, or DECODE of a NOP)
//   busy/halted/err - status; err is sticky until reset
//   instr_count     - retired instructions (wraps)
// Build option: define STAGE_CTRL_STEP_EN to park in PAUSE after every WB
// until a step pulse.
module stage_ctrl
  import cpu_pkg::*;
#(
  parameter int OPC_W       = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  input  logic             step,
  output logic             en_fetch,
  output logic             en_decode,
  output logic             en_mux,
  output logic             en_alu,
  output logic             en_mem,
  output logic             en_wb,
  output logic             alu_in_sel,
  output logic             mem_we,
  output logic             pc_inc,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic             alu_in_sel_q, alu_in_sel_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             timeout;

  logic [1:0] cls;
  logic       is_hlt;

  assign cls    = opcode[OPC_W-1 -: 2];
  assign is_hlt = (opcode == OPC_W'(OP_HLT));

`ifndef STAGE_CTRL_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  // Counter is held clear outside MEM, so it starts from zero on every entry.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != S_MEM),
    .en      ((state_q == S_MEM) && !mem_ready),
    .timeout (timeout)
  );

  always_comb begin
    state_d       = state_q;
    alu_in_sel_d  = alu_in_sel_q;
    instr_count_d = instr_count_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_FETCH;
      S_FETCH:        state_d = S_DECODE;
      S_DECODE: begin
        case (cls)
          CLS_REG: begin
            alu_in_sel_d = 1'b1;
            state_d      = S_MUX;
          end
          CLS_IMM, CLS_MEM: begin
            alu_in_sel_d = 1'b0;
            state_d      = S_MUX;
          end
          // Control ops never reach the ALU, so the operand select is left alone.
          CLS_CTL: state_d = is_hlt ? S_HALT : S_FETCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MUX: state_d = S_ALU;
      S_ALU: state_d = (cls == CLS_MEM) ? S_MEM : S_WB;
      S_MEM: begin
        // A late mem_ready in the timeout cycle still completes the access.
        if (mem_ready)    state_d = S_WB;
        else if (timeout) state_d = S_ERR;
      end
      S_WB: begin
        instr_count_d = instr_count_q + 1'b1;
        if (halt_req) state_d = S_HALT;
`ifdef STAGE_CTRL_STEP_EN
        else          state_d = S_PAUSE;
`else
        else          state_d = S_FETCH;
`endif
      end
`ifdef STAGE_CTRL_STEP_EN
      S_PAUSE: if (step) state_d = S_FETCH;
`endif
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      alu_in_sel_q  <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      alu_in_sel_q  <= alu_in_sel_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Outputs decode straight from the state flops, so an asynchronous reset
  // clears them in the same cycle.
  always_comb begin
    en_fetch    = (state_q == S_FETCH);
    en_decode   = (state_q == S_DECODE);
    en_mux      = (state_q == S_MUX);
    en_alu      = (state_q == S_ALU);
    en_mem      = (state_q == S_MEM);
    en_wb       = (state_q == S_WB);
    mem_we      = (state_q == S_MEM) && opcode[STORE_BIT];
    pc_inc      = (state_q == S_WB) ||
                  ((state_q == S_DECODE) && (cls == CLS_CTL) && !is_hlt);
    busy        = !((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR));
    halted      = (state_q == S_HALT);
    err         = (state_q == S_ERR);
    alu_in_sel  = alu_in_sel_q;
    instr_count = instr_count_q;
  end

endmodule

// File: tb/tb_stage_ctrl.sv
// tb_stage_ctrl: directed test of stage_ctrl with hand-computed expectations.
module tb_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic [4:0]  opcode = 5'b0;
  logic        mem_ready = 1'b0;
  logic        step = 1'b0;
  logic        en_fetch, en_decode, en_mux, en_alu, en_mem, en_wb;
  logic        alu_in_sel, mem_we, pc_inc, busy, halted, err;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] EN_0   = 6'b000000;
  localparam logic [5:0] EN_F   = 6'b100000;
  localparam logic [5:0] EN_D   = 6'b010000;
  localparam logic [5:0] EN_M   = 6'b001000;
  localparam logic [5:0] EN_A   = 6'b000100;
  localparam logic [5:0] EN_MEM = 6'b000010;
  localparam logic [5:0] EN_W   = 6'b000001;

  logic [5:0] en;
  assign en = {en_fetch, en_decode, en_mux, en_alu, en_mem, en_wb};

  stage_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .step        (step),
    .en_fetch    (en_fetch),
    .en_decode   (en_decode),
    .en_mux      (en_mux),
    .en_alu      (en_alu),
    .en_mem      (en_mem),
    .en_wb       (en_wb),
    .alu_in_sel  (alu_in_sel),
    .mem_we      (mem_we),
    .pc_inc      (pc_inc),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves WB; in step builds also verifies the PAUSE hold and releases it.
  task automatic leave_wb();
    tick();
`ifdef STAGE_CTRL_STEP_EN
    check("pause_en", 32'(en), 32'(EN_0));
    check("pause_busy", 32'(busy), 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst_en", 32'(en), 32'(EN_0));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(instr_count), 32'd0);
    check("rst_sel", 32'(alu_in_sel), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    tick();
    rst = 1'b1;

    // Register op 00010
    opcode = 5'b00010;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("reg_fetch", 32'(en), 32'(EN_F));
    check("reg_busy", 32'(busy), 32'd1);
    start = 1'b1;  // ignored while busy
    tick();
    start = 1'b0;
    check("reg_decode", 32'(en), 32'(EN_D));
    check("reg_dec_pcinc", 32'(pc_inc), 32'd0);
    tick();
    check("reg_mux", 32'(en), 32'(EN_M));
    check("reg_sel", 32'(alu_in_sel), 32'd1);
    tick();
    check("reg_alu", 32'(en), 32'(EN_A));
    tick();
    check("reg_wb", 32'(en), 32'(EN_W));
    check("reg_wb_pcinc", 32'(pc_inc), 32'd1);
    check("reg_wb_cnt", 32'(instr_count), 32'd0);
    leave_wb();
    check("reg_next_fetch", 32'(en), 32'(EN_F));
    check("reg_cnt", 32'(instr_count), 32'd1);

    // Reset while in ALU
    opcode = 5'b00000;
    tick();
    tick();
    tick();
    check("mid_alu", 32'(en), 32'(EN_A));
    rst = 1'b0;
    #1;
    check("mid_rst_en", 32'(en), 32'(EN_0));
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cnt", 32'(instr_count), 32'd0);
    check("mid_rst_sel", 32'(alu_in_sel), 32'd0);
    check("mid_rst_pcinc", 32'(pc_inc), 32'd0);
    tick();
    rst    = 1'b1;
    start  = 1'b1;
    opcode = 5'b01000;
    tick();
    start = 1'b0;
    check("start_fetch", 32'(en), 32'(EN_F));

    // Immediate op then store with 3 wait cycles
    tick();
    tick();
    check("imm_sel", 32'(alu_in_sel), 32'd0);
    tick();
    tick();
    check("imm_wb", 32'(en), 32'(EN_W));
    leave_wb();
    check("st_fetch", 32'(en), 32'(EN_F));
    opcode = 5'b10001;
    tick();
    tick();
    tick();
    check("st_alu", 32'(en), 32'(EN_A));
    tick();
    for (int k = 0; k < 4; k++) begin
      check("st_mem", 32'(en), 32'(EN_MEM));
      check("st_we", 32'(mem_we), 32'd1);
      mem_ready = (k == 3);
      tick();
    end
    mem_ready = 1'b0;
    check("st_wb", 32'(en), 32'(EN_W));
    leave_wb();
    check("st_cnt", 32'(instr_count), 32'd2);

    // Load with mem_ready arriving in the timeout cycle itself
    opcode = 5'b10000;
    tick();
    tick();
    tick();
    tick();
    for (int k = 0; k < 16; k++) begin
      check("edge_mem", 32'(en), 32'(EN_MEM));
      check("edge_we", 32'(mem_we), 32'd0);
      mem_ready = (k == 15);
      tick();
    end
    mem_ready = 1'b0;
    check("edge_wb", 32'(en), 32'(EN_W));
    check("edge_err", 32'(err), 32'd0);
    leave_wb();
    check("edge_cnt", 32'(instr_count), 32'd3);

    // Load with mem_ready stuck low: 15 wait cycles then timeout cycle -> ERR
    tick();
    tick();
    tick();
    tick();
    for (int k = 0; k < 16; k++) begin
      check("to_mem", 32'(en), 32'(EN_MEM));
      tick();
    end
    check("to_err", 32'(err), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_en", 32'(en), 32'(EN_0));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("to_start_ign", 32'(err), 32'd1);
    check("to_start_en", 32'(en), 32'(EN_0));
    rst = 1'b0;
    #1;
    check("to_rst_err", 32'(err), 32'd0);
    check("to_rst_cnt", 32'(instr_count), 32'd0);
    tick();
    rst = 1'b1;

    // NOP then HLT
    start  = 1'b1;
    opcode = 5'b11000;
    tick();
    start = 1'b0;
    check("nop_fetch", 32'(en), 32'(EN_F));
    tick();
    check("nop_decode", 32'(en), 32'(EN_D));
    check("nop_pcinc", 32'(pc_inc), 32'd1);
    tick();
    check("nop_refetch", 32'(en), 32'(EN_F));
    check("nop_fetch_pcinc", 32'(pc_inc), 32'd0);
    opcode = 5'b11111;
    tick();
    check("hlt_pcinc", 32'(pc_inc), 32'd0);
    tick();
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_busy", 32'(busy), 32'd0);
    check("hlt_cnt", 32'(instr_count), 32'd0);

    // Restart from HALT; halt_req outside WB ignored, inside WB halts
    start  = 1'b1;
    opcode = 5'b00001;
    tick();
    start = 1'b0;
    check("rs_fetch", 32'(en), 32'(EN_F));
    check("rs_halted", 32'(halted), 32'd0);
    tick();
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("hr_alu", 32'(en), 32'(EN_A));
    tick();
    check("hr_wb", 32'(en), 32'(EN_W));
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("hr_halted", 32'(halted), 32'd1);
    check("hr_en", 32'(en), 32'(EN_0));
    check("hr_cnt", 32'(instr_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
